// File: rtl/de_sel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : de_sel_scan_ctrl
// Brief    : Scans a 4-bit channel word onto a 1-to-4 active-low de-selector,
//            holding each channel for DWELL cycles. Optional macro
//            DE_SEL_SKIP_ZERO_EN skips channels whose bit is 0.
// Revision : 1.0
// ============================================================================
module de_sel_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iValid,
    input  logic [3:0] iData,
    output logic       oReady,
    output logic       oC,
    output logic       oS1,
    output logic       oS0,
    output logic       oBusy,
    output logic       oDone
);

    localparam int               c_CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CW-1:0]  c_CNT_MAX = c_CW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state, w_nextState;
    logic [3:0]      r_word,  w_nextWord;
    logic [1:0]      r_chan,  w_nextChan;
    logic [c_CW-1:0] r_cnt,   w_nextCnt;
    logic            w_scan;

`ifdef DE_SEL_SKIP_ZERO_EN
    logic [2:0] w_hit;

    // Returns {found, index} of the lowest set bit at or above 'from'.
    function automatic logic [2:0] findSet(input logic [3:0] word, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (word[i] && (3'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextWord  = r_word;
        w_nextChan  = r_chan;
        w_nextCnt   = r_cnt;
`ifdef DE_SEL_SKIP_ZERO_EN
        w_hit       = 3'b000;
`endif
        case (r_state)
            ST_IDLE: begin
                if (iValid) begin
                    w_nextWord = iData;
                    w_nextCnt  = '0;
`ifdef DE_SEL_SKIP_ZERO_EN
                    w_hit = findSet(iData, 3'd0);
                    if (w_hit[2]) begin
                        w_nextState = ST_SCAN;
                        w_nextChan  = w_hit[1:0];
                    end else begin
                        w_nextState = ST_DONE;
                        w_nextChan  = 2'd0;
                    end
`else
                    w_nextState = ST_SCAN;
                    w_nextChan  = 2'd0;
`endif
                end
            end
            ST_SCAN: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_nextCnt = '0;
`ifdef DE_SEL_SKIP_ZERO_EN
                    w_hit = findSet(r_word, {1'b0, r_chan} + 3'd1);
                    if (w_hit[2]) begin
                        w_nextChan = w_hit[1:0];
                    end else begin
                        w_nextState = ST_DONE;
                        w_nextChan  = 2'd0;
                    end
`else
                    if (r_chan == 2'd3) begin
                        w_nextState = ST_DONE;
                        w_nextChan  = 2'd0;
                    end else begin
                        w_nextChan = r_chan + 2'd1;
                    end
`endif
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
                w_nextWord  = 4'd0;
                w_nextChan  = 2'd0;
                w_nextCnt   = '0;
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextWord  = 4'd0;
                w_nextChan  = 2'd0;
                w_nextCnt   = '0;
            end
        endcase
    end

    assign w_scan = (w_nextState == ST_SCAN);

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_word  <= 4'd0;
            r_chan  <= 2'd0;
            r_cnt   <= '0;
            oReady  <= 1'b1;
            oC      <= 1'b1;
            oS1     <= 1'b0;
            oS0     <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_word  <= w_nextWord;
            r_chan  <= w_nextChan;
            r_cnt   <= w_nextCnt;
            oReady  <= (w_nextState == ST_IDLE);
            oBusy   <= w_scan;
            oDone   <= (w_nextState == ST_DONE);
            oS1     <= w_scan ? w_nextChan[1] : 1'b0;
            oS0     <= w_scan ? w_nextChan[0] : 1'b0;
            oC      <= w_scan ? ~w_nextWord[w_nextChan] : 1'b1;
        end
    end

endmodule
`default_nettype wire
